// File: rtl/nic_pkg.sv
// Shared NIC definitions: frame header field positions, MAC tuser bit positions and
// the RX state encodings.
package nic_pkg;

    localparam int unsigned HDR_LEN_LSB = 32;
    localparam int unsigned HDR_LEN_MSB = 47;
    localparam int unsigned HDR_DES_LSB = 16;
    localparam int unsigned HDR_DES_MSB = 23;
    localparam int unsigned HDR_SRC_LSB = 0;
    localparam int unsigned HDR_SRC_MSB = 7;

    localparam int unsigned TUSER_SRC_LSB = 0;
    localparam int unsigned TUSER_SRC_MSB = 7;
    localparam int unsigned TUSER_DES_LSB = 16;
    localparam int unsigned TUSER_DES_MSB = 23;
    localparam int unsigned TUSER_BAD_BIT = 32;

    localparam int unsigned PORT_W = 8;
    localparam int unsigned LEN_W  = 16;

    typedef enum logic [3:0] {
        StIdle = 4'b0001,
        StData = 4'b0010,
        StHdr  = 4'b0100,
        StDrop = 4'b1000
    } rx_state_e;

    function automatic logic [63:0] make_hdr(input logic [LEN_W-1:0]  len,
                                             input logic [PORT_W-1:0] des,
                                             input logic [PORT_W-1:0] src);
        logic [63:0] hdr;
        hdr = '0;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB] = len;
        hdr[HDR_DES_MSB:HDR_DES_LSB] = des;
        hdr[HDR_SRC_MSB:HDR_SRC_LSB] = src;
        return hdr;
    endfunction

endpackage

// File: rtl/rx_tstrb_bytes.sv
// Byte count of a contiguous-from-bit-0 tstrb mask (0x00 -> 0, 0xFF -> 8).
module rx_tstrb_bytes (
    input  logic [7:0] tstrb,
    output logic [3:0] bytes
);

    always_comb begin
        bytes = 4'd0;
        for (int i = 0; i < 8; i++) begin
            bytes = bytes + {3'd0, tstrb[i]};
        end
    end

endmodule

// File: rtl/rx_mac_interface.sv
// MAC RX stream to circular frame buffer writer; publishes whole good frames only.
// Optional dropped-frame statistics are enabled with `define RX_MAC_DROP_STATS_EN.
module rx_mac_interface
    import nic_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned MAX_QWORDS = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       s_axis_tdata,
    input  logic [7:0]        s_axis_tstrb,
    input  logic [127:0]      s_axis_tuser,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] commited_wr_addr,
    input  logic [ADDR_W-1:0] commited_rd_addr,
    output logic [31:0]       rx_dropped_frames
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

    rx_state_e         state_q;
    logic              tready_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] commit_q;
    logic [LEN_W-1:0]  count_q;
    logic [PORT_W-1:0] src_q;
    logic [PORT_W-1:0] des_q;
    logic              bad_q;
    logic [3:0]        last_bytes_q;

    logic [ADDR_W-1:0] free;
    logic [ADDR_W-1:0] commit_next;
    logic [LEN_W-1:0]  byte_len;
    logic [3:0]        strb_bytes;
    logic              beat;
    logic              room_first;
    logic              overflow;
    logic              unused_tuser;

    assign unused_tuser = ^{s_axis_tuser[127:33], s_axis_tuser[31:24], s_axis_tuser[15:8]};

    rx_tstrb_bytes u_tstrb_bytes (
        .tstrb (s_axis_tstrb),
        .bytes (strb_bytes)
    );

    assign s_axis_tready = tready_q & ~reset;
    assign beat          = s_axis_tvalid & s_axis_tready;

    // One slot is always left unused so that full and empty stay distinguishable.
    assign free        = commited_rd_addr - wr_ptr_q - ONE;
    assign room_first  = free >= TWO;
    assign overflow    = (free == '0) || (count_q == LEN_W'(MAX_QWORDS));
    assign commit_next = commit_q + ONE + ADDR_W'(count_q);
    assign byte_len    = ((count_q - LEN_W'(1)) << 3) + LEN_W'(last_bytes_q);

    assign commited_wr_addr = commit_q;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (beat && room_first) begin
                        wr_en   = 1'b1;
                        wr_addr = commit_q + ONE;
                        wr_data = s_axis_tdata;
                    end
                end
                StData: begin
                    if (beat && !overflow) begin
                        wr_en   = 1'b1;
                        wr_addr = wr_ptr_q;
                        wr_data = s_axis_tdata;
                    end
                end
                StHdr: begin
                    if (!bad_q) begin
                        wr_en   = 1'b1;
                        wr_addr = commit_q;
                        wr_data = make_hdr(byte_len, des_q, src_q);
                    end
                end
                StDrop: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            tready_q     <= 1'b0;
            wr_ptr_q     <= '0;
            commit_q     <= '0;
            count_q      <= '0;
            src_q        <= '0;
            des_q        <= '0;
            bad_q        <= 1'b0;
            last_bytes_q <= '0;
        end else begin
            tready_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (beat) begin
                        if (room_first) begin
                            src_q        <= s_axis_tuser[TUSER_SRC_MSB:TUSER_SRC_LSB];
                            des_q        <= s_axis_tuser[TUSER_DES_MSB:TUSER_DES_LSB];
                            bad_q        <= s_axis_tuser[TUSER_BAD_BIT];
                            last_bytes_q <= strb_bytes;
                            count_q      <= LEN_W'(1);
                            wr_ptr_q     <= commit_q + TWO;
                            if (s_axis_tlast) begin
                                state_q  <= StHdr;
                                tready_q <= 1'b0;
                            end else begin
                                state_q <= StData;
                            end
                        end else if (!s_axis_tlast) begin
                            state_q <= StDrop;
                        end
                    end
                end
                StData: begin
                    if (beat) begin
                        if (overflow) begin
                            // A single-beat overrun that is also tlast has nothing left to discard.
                            if (s_axis_tlast) begin
                                wr_ptr_q <= commit_q;
                                state_q  <= StIdle;
                            end else begin
                                state_q <= StDrop;
                            end
                        end else begin
                            wr_ptr_q <= wr_ptr_q + ONE;
                            count_q  <= count_q + LEN_W'(1);
                            if (s_axis_tlast) begin
                                bad_q        <= s_axis_tuser[TUSER_BAD_BIT];
                                last_bytes_q <= strb_bytes;
                                state_q      <= StHdr;
                                tready_q     <= 1'b0;
                            end
                        end
                    end
                end
                StHdr: begin
                    if (!bad_q) begin
                        commit_q <= commit_next;
                        wr_ptr_q <= commit_next;
                    end else begin
                        wr_ptr_q <= commit_q;
                    end
                    state_q <= StIdle;
                end
                StDrop: begin
                    if (beat && s_axis_tlast) begin
                        wr_ptr_q <= commit_q;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef RX_MAC_DROP_STATS_EN
    logic        drop_evt;
    logic [31:0] drop_cnt_q;

    always_comb begin
        drop_evt = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StIdle:  drop_evt = beat && !room_first && s_axis_tlast;
                StData:  drop_evt = beat && overflow && s_axis_tlast;
                StHdr:   drop_evt = bad_q;
                StDrop:  drop_evt = beat && s_axis_tlast;
                default: drop_evt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop_evt && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign rx_dropped_frames = drop_cnt_q;
`else
    assign rx_dropped_frames = 32'd0;
`endif

endmodule

// File: tb/tb_rx_mac_interface.sv
// Directed bench for rx_mac_interface: a default-size instance plus a 16-entry instance
// for the wrap-around case.
module tb_rx_mac_interface;

`ifdef RX_MAC_DROP_STATS_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    logic         clk = 1'b0;
    logic         reset10 = 1'b1;
    logic         reset4 = 1'b1;
    logic [63:0]  tdata = '0;
    logic [7:0]   tstrb = '0;
    logic [127:0] tuser = '0;
    logic         tvalid = 1'b0;
    logic         tlast = 1'b0;

    logic         rdy10;
    logic [9:0]   wr_addr10;
    logic [63:0]  wr_data10;
    logic         wr_en10;
    logic [9:0]   commit10;
    logic [9:0]   rd10 = '0;
    logic [31:0]  drops10;

    logic         rdy4;
    logic [3:0]   wr_addr4;
    logic [63:0]  wr_data4;
    logic         wr_en4;
    logic [3:0]   commit4;
    logic [3:0]   rd4 = '0;
    logic [31:0]  drops4;

    logic [63:0]  mem10 [1024];
    logic [63:0]  mem4 [16];

    int vectors = 0;
    int miscompares = 0;

    bit         win = 1'b0;
    int         bubbles = 0;
    logic [3:0] last_c4 = '0;
    logic [3:0] hist [$];

    always #5 clk = ~clk;

    rx_mac_interface #(.ADDR_W(10), .MAX_QWORDS(1023)) dut (
        .clk               (clk),
        .reset             (reset10),
        .s_axis_tdata      (tdata),
        .s_axis_tstrb      (tstrb),
        .s_axis_tuser      (tuser),
        .s_axis_tvalid     (tvalid),
        .s_axis_tlast      (tlast),
        .s_axis_tready     (rdy10),
        .wr_addr           (wr_addr10),
        .wr_data           (wr_data10),
        .wr_en             (wr_en10),
        .commited_wr_addr  (commit10),
        .commited_rd_addr  (rd10),
        .rx_dropped_frames (drops10)
    );

    rx_mac_interface #(.ADDR_W(4), .MAX_QWORDS(1023)) dut4 (
        .clk               (clk),
        .reset             (reset4),
        .s_axis_tdata      (tdata),
        .s_axis_tstrb      (tstrb),
        .s_axis_tuser      (tuser),
        .s_axis_tvalid     (tvalid),
        .s_axis_tlast      (tlast),
        .s_axis_tready     (rdy4),
        .wr_addr           (wr_addr4),
        .wr_data           (wr_data4),
        .wr_en             (wr_en4),
        .commited_wr_addr  (commit4),
        .commited_rd_addr  (rd4),
        .rx_dropped_frames (drops4)
    );

    always @(posedge clk) begin
        if (wr_en10) mem10[wr_addr10] <= wr_data10;
        if (wr_en4) mem4[wr_addr4] <= wr_data4;
    end

    always @(negedge clk) begin
        if (win) begin
            if (!rdy4) bubbles++;
            if (commit4 != last_c4) begin
                hist.push_back(commit4);
                last_c4 = commit4;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_user(input logic [7:0] src, input logic [7:0] des,
                                             input logic bad);
        logic [127:0] u;
        u = '0;
        u[7:0] = src;
        u[23:16] = des;
        u[32] = bad;
        return u;
    endfunction

    task automatic send_beat(input bit sel, input logic [63:0] d, input logic [7:0] s,
                             input logic [127:0] u, input logic l);
        int n;
        tdata = d;
        tstrb = s;
        tuser = u;
        tlast = l;
        tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(sel ? rdy4 : rdy10) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("tready_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit sel, input int n, input logic [63:0] base,
                              input logic [7:0] last_strb, input logic [7:0] src,
                              input logic [7:0] des, input logic bad, input bit keep);
        for (int i = 0; i < n; i++) begin
            send_beat(sel, base + 64'(i), (i == n - 1) ? last_strb : 8'hFF,
                      mk_user(src, des, (i == n - 1) ? bad : 1'b0), i == n - 1);
        end
        if (!keep) begin
            tvalid = 1'b0;
            tlast = 1'b0;
        end
    endtask

    task automatic reset_dut10();
        tvalid = 1'b0;
        tlast = 1'b0;
        reset10 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset10 = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tready", 64'(rdy10), 64'd0);
        check("rst_wr_en", 64'(wr_en10), 64'd0);
        check("rst_commit", 64'(commit10), 64'd0);
        check("rst_drops", drops10, 64'd0);
        @(posedge clk);
        #1;
        reset10 = 1'b0;

        // 8 full beats
        rd10 = 10'd0;
        send_frame(0, 8, 64'h1111_0000_0000_0000, 8'hFF, 8'h01, 8'h02, 1'b0, 0);
        @(negedge clk);
        check("t1_hdr_tready", 64'(rdy10), 64'd0);
        check("t1_commit_pre", 64'(commit10), 64'd0);
        @(posedge clk);
        #1;
        check("t1_commit", 64'(commit10), 64'd9);
        check("t1_hdr", mem10[0], 64'h0000_0040_0002_0001);
        check("t1_pay1", mem10[1], 64'h1111_0000_0000_0000);
        check("t1_pay8", mem10[8], 64'h1111_0000_0000_0007);

        // 8 beats, partial last
        reset_dut10();
        send_frame(0, 8, 64'h2222_0000_0000_0000, 8'h1F, 8'h03, 8'h04, 1'b0, 0);
        @(posedge clk);
        #1;
        check("t2_commit", 64'(commit10), 64'd9);
        check("t2_hdr", mem10[0], 64'h0000_003D_0004_0003);

        // Insufficient space drops the frame
        reset_dut10();
        rd10 = 10'd5;
        send_frame(0, 10, 64'h3333_0000_0000_0000, 8'hFF, 8'h05, 8'h06, 1'b0, 0);
        @(posedge clk);
        #1;
        check("t3_commit_drop", 64'(commit10), 64'd0);
        check("t3_drops", drops10, 64'(DROP_EN));
        rd10 = 10'h3FF;
        send_frame(0, 2, 64'h3344_0000_0000_0000, 8'hFF, 8'h05, 8'h06, 1'b0, 0);
        @(posedge clk);
        #1;
        check("t3_commit_ok", 64'(commit10), 64'd3);
        check("t3_hdr", mem10[0], 64'h0000_0010_0006_0005);
        check("t3_pay2", mem10[2], 64'h3344_0000_0000_0001);

        // Bad-frame flag
        reset_dut10();
        rd10 = 10'd0;
        send_frame(0, 2, 64'h4444_0000_0000_0000, 8'h01, 8'h07, 8'h08, 1'b0, 0);
        @(posedge clk);
        #1;
        check("t4_commit_first", 64'(commit10), 64'd3);
        check("t4_hdr_first", mem10[0], 64'h0000_0009_0008_0007);
        send_frame(0, 4, 64'h4455_0000_0000_0000, 8'hFF, 8'h07, 8'h08, 1'b1, 0);
        @(negedge clk);
        check("t4_bad_no_hdr", 64'(wr_en10), 64'd0);
        @(posedge clk);
        #1;
        check("t4_bad_commit", 64'(commit10), 64'd3);
        check("t4_bad_drops", drops10, 64'(DROP_EN));
        send_frame(0, 3, 64'h4466_0000_0000_0000, 8'hFF, 8'h09, 8'h0A, 1'b0, 0);
        @(posedge clk);
        #1;
        check("t4_next_commit", 64'(commit10), 64'd7);
        check("t4_next_hdr", mem10[3], 64'h0000_0018_000A_0009);
        check("t4_next_pay", mem10[4], 64'h4466_0000_0000_0000);

        // Reset mid-frame
        reset_dut10();
        send_frame(0, 8, 64'h6666_0000_0000_0000, 8'hFF, 8'h01, 8'h01, 1'b0, 0);
        @(posedge clk);
        #1;
        check("t6_commit_pre", 64'(commit10), 64'd9);
        send_beat(0, 64'h6677_0000_0000_0000, 8'hFF, mk_user(8'h11, 8'h22, 1'b0), 1'b0);
        send_beat(0, 64'h6677_0000_0000_0001, 8'hFF, mk_user(8'h11, 8'h22, 1'b0), 1'b0);
        reset10 = 1'b1;
        tdata = 64'h6677_0000_0000_0002;
        @(negedge clk);
        check("t6_rst_tready", 64'(rdy10), 64'd0);
        check("t6_rst_wr_en", 64'(wr_en10), 64'd0);
        check("t6_rst_wr_addr", 64'(wr_addr10), 64'd0);
        check("t6_rst_wr_data", wr_data10, 64'd0);
        @(posedge clk);
        #1;
        check("t6_rst_commit", 64'(commit10), 64'd0);
        check("t6_rst_drops", drops10, 64'd0);
        tvalid = 1'b0;
        reset10 = 1'b0;
        send_frame(0, 5, 64'h6688_0000_0000_0000, 8'hFF, 8'h11, 8'h22, 1'b0, 0);
        @(posedge clk);
        #1;
        check("t6_commit", 64'(commit10), 64'd6);
        check("t6_hdr", mem10[0], 64'h0000_0028_0022_0011);
        check("t6_pay1", mem10[1], 64'h6688_0000_0000_0000);

        // Wrap-around on the 16-entry buffer
        reset10 = 1'b1;
        rd4 = 4'd0;
        reset4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset4 = 1'b0;
        send_frame(1, 11, 64'h5555_0000_0000_0000, 8'hFF, 8'h00, 8'h00, 1'b0, 0);
        @(posedge clk);
        #1;
        check("t5_fill_commit", 64'(commit4), 64'd12);
        rd4 = 4'd12;
        last_c4 = 4'd12;
        bubbles = 0;
        win = 1'b1;
        send_frame(1, 3, 64'h5A00_0000_0000_0000, 8'hFF, 8'h01, 8'h02, 1'b0, 1);
        send_frame(1, 3, 64'h5B00_0000_0000_0000, 8'hFF, 8'h03, 8'h04, 1'b0, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        win = 1'b0;
        check("t5_bubbles", 64'(bubbles), 64'd2);
        check("t5_hist_size", 64'(hist.size()), 64'd2);
        check("t5_commit_a", 64'(hist[0]), 64'd0);
        check("t5_commit_b", 64'(hist[1]), 64'd4);
        check("t5_hdr_a", mem4[12], 64'h0000_0018_0002_0001);
        check("t5_pay_a", mem4[15], 64'h5A00_0000_0000_0002);
        check("t5_hdr_b", mem4[0], 64'h0000_0018_0004_0003);
        check("t5_pay_b1", mem4[1], 64'h5B00_0000_0000_0000);
        check("t5_pay_b3", mem4[3], 64'h5B00_0000_0000_0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
